// File: rtl/shiftreg_unbuf_pkg.sv
// Shared code-block constants and FSM encoding for the byte-out shift buffer.
package shiftreg_unbuf_pkg;

  localparam int CB_SMALL_BITS = 1056;
  localparam int CB_LARGE_BITS = 6144;
  localparam int CB_BYTE_W     = 8;
  localparam int CB_SMALL_NB   = CB_SMALL_BITS / CB_BYTE_W;
  localparam int CB_LARGE_NB   = CB_LARGE_BITS / CB_BYTE_W;
  localparam int CB_CNT_W      = 10;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/shiftreg_unbuf.sv
// Parallel-load code block, stream it out LSB-first one byte per handshake.
// First byte valid one cycle after load; byte_out/sof/eof hold while byte_ready is low.
module shiftreg_unbuf
  import shiftreg_unbuf_pkg::*;
#(
  parameter int BLK_W    = CB_LARGE_BITS,
  parameter int BYTE_W   = CB_BYTE_W,
  parameter int SMALL_NB = CB_SMALL_NB,
  parameter int LARGE_NB = CB_LARGE_NB,
  parameter int CNT_W    = CB_CNT_W
) (
  input  logic              clk,
  input  logic              aclr_n,
  input  logic              flush,
  input  logic              load,
  output logic              load_ready,
  input  logic              blk_sel,
  input  logic [BLK_W-1:0]  data_in,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              sof,
  output logic              eof,
  output logic              done
);

  state_t             state, state_nxt;
  logic [BLK_W-1:0]   mem;
  logic [CNT_W-1:0]   count;
  logic               first;
  logic               hs;
  logic               last_hs;

  assign hs      = (state == ST_SHIFT) && byte_ready;
  assign last_hs = hs && (count == '0);

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    byte_valid = 1'b0;
    byte_out   = '0;
    sof        = 1'b0;
    eof        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        load_ready = 1'b1;
        if (load && !flush) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        byte_valid = 1'b1;
        byte_out   = mem[BYTE_W-1:0];
        sof        = first;
        eof        = (count == '0);
        if (flush || last_hs) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Flush outranks both load and handshake so a dropped block leaves no residue.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      mem   <= '0;
      count <= '0;
      first <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= last_hs && !flush;
      if (flush) begin
        mem   <= '0;
        count <= '0;
        first <= 1'b0;
      end else if (state == ST_IDLE && load) begin
        mem   <= data_in;
        count <= blk_sel ? CNT_W'(LARGE_NB - 1) : CNT_W'(SMALL_NB - 1);
        first <= 1'b1;
      end else if (hs) begin
        mem   <= {{BYTE_W{1'b0}}, mem[BLK_W-1:BYTE_W]};
        first <= 1'b0;
        if (count != '0) count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shiftreg_unbuf.sv
// Scoreboarded bench: stimulus pushes the expected byte stream, a negedge monitor pops and compares.
module tb_shiftreg_unbuf;

  localparam int BLK_W = 6144;

  logic             clk = 1'b0;
  logic             aclr_n = 1'b0;
  logic             flush = 1'b0;
  logic             load = 1'b0;
  logic             load_ready;
  logic             blk_sel = 1'b0;
  logic [BLK_W-1:0] data_in = '0;
  logic [7:0]       byte_out;
  logic             byte_valid;
  logic             byte_ready = 1'b0;
  logic             sof, eof, done;

  shiftreg_unbuf dut (
    .clk(clk), .aclr_n(aclr_n), .flush(flush), .load(load), .load_ready(load_ready),
    .blk_sel(blk_sel), .data_in(data_in), .byte_out(byte_out), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .sof(sof), .eof(eof), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic s; logic e; logic [7:0] b; } exp_t;
  exp_t q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  int blk_base = 0;
  int rdy_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // byte_ready driver: 0 = always ready, 1 = pattern 1,0,0,1,0,1, 2 = random
  initial begin
    int idx = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: byte_ready = 1'b1;
        1: begin
          byte_ready = (idx % 6 == 0) || (idx % 6 == 3) || (idx % 6 == 5);
          idx++;
        end
        default: byte_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor
  initial begin
    logic done_exp = 1'b0;
    logic stall_prev = 1'b0;
    logic [7:0] b_prev = '0;
    logic s_prev = 1'b0, e_prev = 1'b0;
    logic hs;
    exp_t x;
    forever begin
      @(negedge clk);
      if (!aclr_n) begin
        done_exp   = 1'b0;
        stall_prev = 1'b0;
      end else begin
        chk("done", {31'b0, done}, {31'b0, done_exp});
        chk("load_ready", {31'b0, load_ready}, {31'b0, !byte_valid});
        if (!byte_valid) chk("idle_byte_zero", {24'b0, byte_out}, 32'h0);
        if (stall_prev) begin
          chk("stall_valid", {31'b0, byte_valid}, 32'h1);
          chk("stall_hold", {22'b0, sof, eof, byte_out}, {22'b0, s_prev, e_prev, b_prev});
        end
        hs = byte_valid && byte_ready && !flush;
        done_exp = hs && eof;
        if (hs) begin
          hs_cnt++;
          if (q.size() == 0) begin
            chk("unexpected_byte", {24'b0, byte_out}, 32'hDEAD);
          end else begin
            x = q.pop_front();
            chk("byte", {22'b0, sof, eof, byte_out}, {22'b0, x.s, x.e, x.b});
          end
        end
        stall_prev = byte_valid && !byte_ready && !flush;
        b_prev = byte_out; s_prev = sof; e_prev = eof;
      end
    end
  end

  task automatic do_load(input logic sel, input logic [BLK_W-1:0] d);
    int nb = sel ? 768 : 132;
    bit ok = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (load_ready) begin ok = 1; break; end
    end
    if (!ok) chk("load_ready_timeout", 32'h0, 32'h1);
    load = 1'b1; blk_sel = sel; data_in = d;
    @(posedge clk);
    #1;
    load = 1'b0;
    blk_base = hs_cnt;
    for (int i = 0; i < nb; i++)
      q.push_back({(i == 0), (i == nb - 1), d[8*i +: 8]});
  endtask

  task automatic wait_block(input int nb);
    bit ok = 0;
    for (int c = 0; c < 8000; c++) begin
      @(negedge clk);
      if (q.size() == 0 && !byte_valid) begin ok = 1; break; end
    end
    chk("block_end_timeout", {31'b0, ok}, 32'h1);
    chk("byte_count", hs_cnt - blk_base, nb);
    chk("load_ready_after", {31'b0, load_ready}, 32'h1);
  endtask

  task automatic wait_bytes(input int n);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (hs_cnt - blk_base >= n) return;
    end
    chk("wait_bytes_timeout", hs_cnt - blk_base, n);
  endtask

  function automatic logic [BLK_W-1:0] rand_blk();
    logic [BLK_W-1:0] d;
    for (int i = 0; i < BLK_W / 32; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  initial begin
    logic [BLK_W-1:0] d;
    // Reset values
    #3;
    chk("rst_load_ready", {31'b0, load_ready}, 32'h1);
    chk("rst_outs", {27'b0, byte_valid, sof, eof, done}, 32'h0);
    chk("rst_byte", {24'b0, byte_out}, 32'h0);
    @(posedge clk); #1 aclr_n = 1'b1;

    // Large block, byte i = i[7:0], always ready
    rdy_mode = 0;
    for (int i = 0; i < 768; i++) d[8*i +: 8] = 8'(i);
    do_load(1'b1, d);
    wait_block(768);

    // Small block, upper bits all ones
    d = '1;
    for (int i = 0; i < 132; i++) d[8*i +: 8] = 8'(i);
    do_load(1'b0, d);
    wait_block(132);

    // Backpressure pattern on a random large block
    rdy_mode = 1;
    do_load(1'b1, rand_blk());
    wait_block(768);

    // Load while busy is ignored, then flush at byte 50
    rdy_mode = 0;
    do_load(1'b1, rand_blk());
    wait_bytes(10);
    load = 1'b1; data_in = rand_blk();
    @(posedge clk); #1 load = 1'b0;
    wait_bytes(50);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    q.delete();
    @(negedge clk);
    chk("flush_valid", {31'b0, byte_valid}, 32'h0);
    chk("flush_done", {31'b0, done}, 32'h0);
    chk("flush_load_ready", {31'b0, load_ready}, 32'h1);

    // flush and load together in IDLE: load dropped
    @(negedge clk);
    flush = 1'b1; load = 1'b1; data_in = rand_blk();
    @(posedge clk); #1 flush = 1'b0; load = 1'b0;
    @(negedge clk);
    chk("flush_load_valid", {31'b0, byte_valid}, 32'h0);

    // Reset mid-block at byte 100, then a clean reload
    do_load(1'b1, rand_blk());
    wait_bytes(100);
    #2 aclr_n = 1'b0;
    #1;
    chk("midrst_load_ready", {31'b0, load_ready}, 32'h1);
    chk("midrst_outs", {27'b0, byte_valid, sof, eof, done}, 32'h0);
    chk("midrst_byte", {24'b0, byte_out}, 32'h0);
    q.delete();
    @(posedge clk); #1 aclr_n = 1'b1;
    do_load(1'b1, rand_blk());
    wait_block(768);

    // Random blocks with random backpressure
    rdy_mode = 2;
    for (int k = 0; k < 4; k++) begin
      logic sel;
      sel = 1'($urandom_range(0, 1));
      do_load(sel, rand_blk());
      wait_block(sel ? 768 : 132);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
